fetch_stage_p: RTL and testbench

Parametrised instruction-fetch stage for the pipelined RV32I core. Holds the fetch PC, selects the next PC (sequential, branch, JALR), drives the instruction-memory address, and registers the fetched word into the IF/ID pipeline register with valid, stall, flush and memory-wait handling. Redirects that arrive while fetch is stalled are held in a pending register, so none is lost. Sits between the hazard unit/execute stage and decode.

---
 rtl/fetch_stage_p.sv | 147 ++++++++++++++
 tb/tb_fetch_stage_p.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage_p.sv
// RV32I instruction-fetch stage: PC register with next-PC selection, a pending
// redirect register for redirects that arrive while fetch is stalled, and the IF/ID register.
module fetch_stage_p #(
    parameter int unsigned    W           = 32,
    parameter logic [W-1:0]   RESET_PC    = '0,
    parameter logic [W-1:0]   NOP         = 'h13,
    parameter bit             ALIGN_CHECK = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   PCsrc,
    input  logic [W-1:0] PCE,
    input  logic [W-1:0] ImmExtE,
    input  logic [W-1:0] ALUResultE,
    input  logic         StallF,
    input  logic         StallD,
    input  logic         FlushD,
    input  logic         ImemReady,
    input  logic [W-1:0] InstrF,
    output logic [W-1:0] PCF,
    output logic [W-1:0] InstrD,
    output logic [W-1:0] PCD,
    output logic [W-1:0] PCPlus4D,
    output logic         ValidD,
    output logic         MisalignF,
    output logic [W-1:0] FetchCount
);

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_RSVD   = 2'b10,
        PC_JALR   = 2'b11
    } pcsrc_e;

    localparam logic [W-1:0] FOUR       = W'(4);
    localparam logic [W-1:0] ONE        = W'(1);
    localparam logic [W-1:0] ALIGN_MASK = ~W'(3);

    logic [W-1:0] r_pcf;
    logic         r_pend_valid;
    logic [W-1:0] r_pend_pc;
    logic [W-1:0] r_instr_d;
    logic [W-1:0] r_pcd;
    logic [W-1:0] r_pcplus4_d;
    logic         r_valid_d;
    logic         r_misalign;
    logic [W-1:0] r_fetch_count;

    logic         w_redirect;
    logic [W-1:0] w_target;
    logic         w_stall_int;
    logic         w_fire;
    logic [W-1:0] w_pc_plus4;

    // PC_RSVD falls through to sequential fetch.
    always_comb begin
        w_redirect = 1'b0;
        w_target   = PCE + ImmExtE;
        case (pcsrc_e'(PCsrc))
            PC_BRANCH: begin
                w_redirect = 1'b1;
                w_target   = PCE + ImmExtE;
            end
            PC_JALR: begin
                w_redirect = 1'b1;
                w_target   = ALUResultE & ~ONE;
            end
            default: begin
                w_redirect = 1'b0;
                w_target   = PCE + ImmExtE;
            end
        endcase
    end

    assign w_stall_int = StallF | ~ImemReady;
    // The word at PCF is wrong-path whenever a redirect is live or still pending.
    assign w_fire      = ~w_stall_int & ~w_redirect & ~r_pend_valid;
    assign w_pc_plus4  = r_pcf + FOUR;

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pcf        <= RESET_PC;
            r_pend_valid <= 1'b0;
            r_pend_pc    <= '0;
            r_misalign   <= 1'b0;
        end else begin
            r_misalign <= ALIGN_CHECK && w_redirect && (w_target[1:0] != 2'b00);
            if (w_stall_int) begin
                if (w_redirect) begin
                    r_pend_pc    <= w_target;
                    r_pend_valid <= 1'b1;
                end
            end else if (w_redirect) begin
                r_pcf        <= w_target & ALIGN_MASK;
                r_pend_valid <= 1'b0;
            end else if (r_pend_valid) begin
                r_pcf        <= r_pend_pc & ALIGN_MASK;
                r_pend_valid <= 1'b0;
            end else begin
                r_pcf <= w_pc_plus4;
            end
        end
    end

    // IF/ID register: flush beats stall, stall beats capture, anything else is a bubble.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_instr_d     <= NOP;
            r_pcd         <= '0;
            r_pcplus4_d   <= '0;
            r_valid_d     <= 1'b0;
            r_fetch_count <= '0;
        end else if (FlushD) begin
            r_instr_d   <= NOP;
            r_pcd       <= '0;
            r_pcplus4_d <= '0;
            r_valid_d   <= 1'b0;
        end else if (StallD) begin
            r_instr_d   <= r_instr_d;
            r_pcd       <= r_pcd;
            r_pcplus4_d <= r_pcplus4_d;
            r_valid_d   <= r_valid_d;
        end else if (w_fire) begin
            r_instr_d     <= InstrF;
            r_pcd         <= r_pcf;
            r_pcplus4_d   <= w_pc_plus4;
            r_valid_d     <= 1'b1;
            r_fetch_count <= r_fetch_count + ONE;
        end else begin
            r_instr_d   <= NOP;
            r_pcd       <= '0;
            r_pcplus4_d <= '0;
            r_valid_d   <= 1'b0;
        end
    end

    assign PCF        = r_pcf;
    assign InstrD     = r_instr_d;
    assign PCD        = r_pcd;
    assign PCPlus4D   = r_pcplus4_d;
    assign ValidD     = r_valid_d;
    assign MisalignF  = r_misalign;
    assign FetchCount = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage_p.sv
// Scoreboard bench for fetch_stage_p: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares; a W=8 instance exercises FetchCount wrap.
module tb_fetch_stage_p;

    logic        clk;
    logic        rst;
    logic [1:0]  PCsrc;
    logic [31:0] PCE, ImmExtE, ALUResultE;
    logic        StallF, StallD, FlushD, ImemReady;
    logic [31:0] InstrF;
    logic [31:0] PCF, InstrD, PCD, PCPlus4D, FetchCount;
    logic        ValidD, MisalignF;

    logic        rst8, flush8, stall8;
    logic [7:0]  instr8, pcf8, instrd8, pcd8, pcp4d8, cnt8;
    logic        valid8, mis8;

    typedef struct {
        logic [31:0] pcf, instr, pcd, p4, cnt;
        logic        valid, mis;
    } exp_t;

    typedef struct {
        logic        chk_instr;
        logic [7:0]  instr, cnt;
        logic        valid;
    } exp8_t;

    exp_t  q[$];
    exp8_t q8[$];
    int    n_vec = 0;
    int    n_err = 0;

    fetch_stage_p #(.W(32), .RESET_PC(32'h0), .NOP(32'h13), .ALIGN_CHECK(1'b1)) dut (
        .clk(clk), .rst(rst), .PCsrc(PCsrc), .PCE(PCE), .ImmExtE(ImmExtE),
        .ALUResultE(ALUResultE), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .ImemReady(ImemReady), .InstrF(InstrF), .PCF(PCF), .InstrD(InstrD), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .ValidD(ValidD), .MisalignF(MisalignF), .FetchCount(FetchCount)
    );

    fetch_stage_p #(.W(8), .RESET_PC(8'h0), .NOP(8'h13), .ALIGN_CHECK(1'b1)) dut8 (
        .clk(clk), .rst(rst8), .PCsrc(2'b00), .PCE(8'h0), .ImmExtE(8'h0),
        .ALUResultE(8'h0), .StallF(1'b0), .StallD(stall8), .FlushD(flush8),
        .ImemReady(1'b1), .InstrF(instr8), .PCF(pcf8), .InstrD(instrd8), .PCD(pcd8),
        .PCPlus4D(pcp4d8), .ValidD(valid8), .MisalignF(mis8), .FetchCount(cnt8)
    );

    function automatic logic [31:0] im(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : {16'hC0DE, a[15:0]};
    endfunction

    assign InstrF = im(PCF);
    assign instr8 = pcf8 ^ 8'h5A;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, act, exp);
        end
    endtask

    exp_t  m;
    exp8_t m8;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            m = q.pop_front();
            check("PCF", PCF, m.pcf);
            check("InstrD", InstrD, m.instr);
            check("PCD", PCD, m.pcd);
            check("PCPlus4D", PCPlus4D, m.p4);
            check("ValidD", {31'b0, ValidD}, {31'b0, m.valid});
            check("MisalignF", {31'b0, MisalignF}, {31'b0, m.mis});
            check("FetchCount", FetchCount, m.cnt);
        end
        if (q8.size() > 0) begin
            m8 = q8.pop_front();
            if (m8.chk_instr) begin
                check("w8_FetchCount", {24'b0, cnt8}, {24'b0, m8.cnt});
                check("w8_ValidD", {31'b0, valid8}, {31'b0, m8.valid});
                check("w8_InstrD", {24'b0, instrd8}, {24'b0, m8.instr});
            end
        end
    end

    task automatic set_in(input logic [1:0] pcsrc, input logic [31:0] pce, input logic [31:0] imm,
                          input logic [31:0] alu, input logic sf, input logic sd,
                          input logic fd, input logic rdy);
        PCsrc = pcsrc; PCE = pce; ImmExtE = imm; ALUResultE = alu;
        StallF = sf; StallD = sd; FlushD = fd; ImemReady = rdy;
    endtask

    task automatic idle();
        set_in(2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic step(input logic [31:0] pcf, input logic [31:0] instr, input logic [31:0] pcd,
                        input logic [31:0] p4, input logic v, input logic mis, input logic [31:0] cnt);
        exp_t e;
        e.pcf = pcf; e.instr = instr; e.pcd = pcd; e.p4 = p4;
        e.valid = v; e.mis = mis; e.cnt = cnt;
        q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic bubble(input logic [31:0] pcf, input logic mis, input logic [31:0] cnt);
        step(pcf, 32'h13, 32'h0, 32'h0, 1'b0, mis, cnt);
    endtask

    task automatic cap(input logic [31:0] pc, input logic [31:0] cnt);
        step(pc + 32'd4, im(pc), pc, pc + 32'd4, 1'b1, 1'b0, cnt);
    endtask

    task automatic step8(input logic chk, input logic [7:0] instr, input logic [7:0] cnt, input logic v);
        exp8_t e;
        e.chk_instr = chk; e.instr = instr; e.cnt = cnt; e.valid = v;
        q8.push_back(e);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got=running exp=finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; rst8 = 1'b0; flush8 = 1'b0; stall8 = 1'b0;
        idle();
        @(negedge clk);
        #1;
        // Reset held three cycles.
        for (int i = 0; i < 3; i++) bubble(32'h0, 1'b0, 32'd0);
        rst = 1'b1;
        step(32'h4, 32'h0050_0093, 32'h0, 32'h4, 1'b1, 1'b0, 32'd1);
        cap(32'h4, 32'd2);
        cap(32'h8, 32'd3);
        cap(32'hC, 32'd4);
        // Branch at PCF=0x10 to 0x08+0x20.
        set_in(2'b01, 32'h08, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        bubble(32'h28, 1'b0, 32'd4);
        idle();
        cap(32'h28, 32'd5);
        // Misaligned JALR.
        set_in(2'b11, 32'h0, 32'h0, 32'h103, 1'b0, 1'b0, 1'b0, 1'b1);
        bubble(32'h100, 1'b1, 32'd5);
        idle();
        cap(32'h100, 32'd6);
        cap(32'h104, 32'd7);
        // Redirect during a full stall, held two more cycles.
        set_in(2'b01, 32'h30, 32'h10, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(32'h108, im(32'h104), 32'h104, 32'h108, 1'b1, 1'b0, 32'd7);
        set_in(2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(32'h108, im(32'h104), 32'h104, 32'h108, 1'b1, 1'b0, 32'd7);
        step(32'h108, im(32'h104), 32'h104, 32'h108, 1'b1, 1'b0, 32'd7);
        idle();
        bubble(32'h40, 1'b0, 32'd7);
        cap(32'h40, 32'd8);
        // Pending redirect superseded by a live JALR.
        set_in(2'b01, 32'h80, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        bubble(32'h44, 1'b0, 32'd8);
        set_in(2'b01, 32'h90, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        bubble(32'h44, 1'b0, 32'd8);
        set_in(2'b11, 32'h0, 32'h0, 32'h200, 1'b0, 1'b0, 1'b0, 1'b1);
        bubble(32'h200, 1'b0, 32'd8);
        idle();
        cap(32'h200, 32'd9);
        // Newer pending redirect overwrites an older one.
        set_in(2'b01, 32'h80, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        bubble(32'h204, 1'b0, 32'd9);
        set_in(2'b01, 32'h90, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        bubble(32'h204, 1'b0, 32'd9);
        idle();
        bubble(32'h90, 1'b0, 32'd9);
        cap(32'h90, 32'd10);
        // Memory wait at PCF=0x20.
        set_in(2'b01, 32'h20, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        bubble(32'h20, 1'b0, 32'd10);
        set_in(2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) bubble(32'h20, 1'b0, 32'd10);
        idle();
        cap(32'h20, 32'd11);
        // Flush and stall together: flush wins.
        set_in(2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        bubble(32'h28, 1'b0, 32'd11);
        idle();
        cap(32'h28, 32'd12);
        // StallD alone holds IF/ID and does not count.
        set_in(2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(32'h30, im(32'h28), 32'h28, 32'h2C, 1'b1, 1'b0, 32'd12);
        idle();
        cap(32'h30, 32'd13);
        // PCsrc=10 behaves as sequential.
        set_in(2'b10, 32'h500, 32'h500, 32'h503, 1'b0, 1'b0, 1'b0, 1'b1);
        cap(32'h34, 32'd14);
        // Reset while a redirect is pending discards it.
        set_in(2'b01, 32'h80, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        bubble(32'h38, 1'b0, 32'd14);
        idle();
        rst = 1'b0;
        bubble(32'h0, 1'b0, 32'd0);
        rst = 1'b1;
        step(32'h4, 32'h0050_0093, 32'h0, 32'h4, 1'b1, 1'b0, 32'd1);

        // W=8 instance: count to 0xFF, flush+stall, then wrap to 0.
        rst8 = 1'b1;
        step8(1'b1, 8'h00 ^ 8'h5A, 8'h01, 1'b1);
        for (int i = 2; i < 255; i++) step8(1'b0, 8'h00, 8'h00, 1'b0);
        step8(1'b1, 8'hF8 ^ 8'h5A, 8'hFF, 1'b1);
        flush8 = 1'b1; stall8 = 1'b1;
        step8(1'b1, 8'h13, 8'hFF, 1'b0);
        flush8 = 1'b0; stall8 = 1'b0;
        step8(1'b1, 8'h00 ^ 8'h5A, 8'h00, 1'b1);

        @(negedge clk);
        #1;
        check("scoreboard_drain", 32'(q.size() + q8.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
